// File: rtl/rect_rom_arbiter.sv
// Round-robin sharing of one rectangle-ROM read port among N_REQ requesters.
// A tag FIFO remembers who issued each in-flight read so in-order ROM data is routed back.
module rect_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W_ADDR  = 14,
  parameter int W_DATA  = 5,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W_ADDR-1:0] req_addr,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [W_DATA-1:0]       rsp_data,
  output logic                    mem_addr_valid,
  input  logic                    mem_addr_ready,
  output logic [W_ADDR-1:0]       mem_addr_data,
  input  logic                    mem_data_valid,
  output logic                    mem_data_ready,
  input  logic [W_DATA-1:0]       mem_data,
  output logic                    err
);

  localparam int W_TAG = $clog2(N_REQ);
  localparam int W_CNT = $clog2(MAX_OUT) + 1;
  localparam int W_FP  = $clog2(MAX_OUT);
  localparam logic [W_TAG:0]   N_SUM   = (W_TAG+1)'(N_REQ);
  localparam logic [W_TAG-1:0] LAST    = W_TAG'(N_REQ - 1);
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(MAX_OUT);

  logic [W_TAG-1:0] rr_ptr;
  logic [W_TAG-1:0] grant;
  logic [W_TAG-1:0] head;
  logic [W_TAG:0]   sum;
  logic             any_valid;
  logic             has_room;
  logic             not_empty;
  logic             issue_fire;
  logic             rsp_fire;
  logic [W_CNT-1:0] count;
  logic [W_FP-1:0]  wr_ptr;
  logic [W_FP-1:0]  rd_ptr;
  logic [W_TAG-1:0] tag_mem [MAX_OUT];

  // First valid requester scanning upward from rr_ptr, wrapping mod N_REQ.
  always_comb begin
    grant     = rr_ptr;
    any_valid = 1'b0;
    sum       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (W_TAG+1)'(k);
      if (sum >= N_SUM) sum = sum - N_SUM;
      if (!any_valid && req_valid[sum[W_TAG-1:0]]) begin
        grant     = sum[W_TAG-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and a stalled grantee keeps its grant because rr_ptr only moves on fire.
  assign has_room       = (count < CNT_MAX);
  assign not_empty      = (count != '0);
  assign mem_addr_valid = any_valid && has_room;
  assign mem_addr_data  = req_addr[int'(grant)*W_ADDR +: W_ADDR];
  assign issue_fire     = mem_addr_valid && mem_addr_ready;
  assign head           = tag_mem[rd_ptr];
  assign rsp_data       = mem_data;
  // With nothing outstanding, stray ROM data is swallowed and flagged via err.
  assign mem_data_ready = not_empty ? rsp_ready[head] : 1'b1;
  assign rsp_fire       = mem_data_valid && mem_data_ready && not_empty;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (any_valid && has_room && mem_addr_ready) req_ready[grant] = 1'b1;
    if (mem_data_valid && not_empty)             rsp_valid[head]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (issue_fire) begin
        rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rsp_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({issue_fire, rsp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_data_valid && !not_empty) err <= 1'b1;
    end
  end

  // Tag storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[wr_ptr] <= grant;
  end

endmodule
